regfile_sequencer: RTL and testbench

Control sequencer for the 8×16-bit register-file datapath: Regfile, A/B operand registers, ALU and C result register. It accepts one command at a time over a valid/ready handshake. It walks a Moore state machine that drives the register file's read/write ports and the datapath load/select strobes, so each command completes as a single register write. It sits between the instruction source (testbench or future decoder) and the datapath. It contains no data storage beyond the captured command fields.

---
 rtl/regfile_sequencer.sv | 141 ++++++++++++++
 tb/tb_regfile_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Moore control sequencer for the Regfile / A / B / ALU / C datapath.
// Accepts one command per valid/ready handshake and retires it as a single register write.
`timescale 1ns/1ps
module regfile_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [2:0]       cmd_rd,
    input  logic [2:0]       cmd_rn,
    input  logic [2:0]       cmd_rm,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             done,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             asel,
    output logic             vsel,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] imm_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_WIMM, S_LDA, S_LDB, S_EXEC, S_WRC, S_FIN
    } state_t;

    typedef enum logic [1:0] {
        OP_MOVI = 2'b00,
        OP_MOV  = 2'b01,
        OP_ADD  = 2'b10,
        OP_NOP  = 2'b11
    } op_t;

    state_t           r_state;
    op_t              r_op;
    logic [2:0]       r_rm;
    logic [WIDTH-1:0] r_imm;
    logic [2:0]       r_readnum;
    logic [2:0]       r_writenum;
    logic             r_ready;
    logic             r_done;
    logic             r_write;
    logic             r_loada;
    logic             r_loadb;
    logic             r_loadc;
    logic             r_asel;
    logic             r_vsel;

    logic             w_accept;
    state_t           w_next;
    logic [2:0]       w_rm;

    assign w_accept = cmd_valid & r_ready;
    // MOV enters LDB straight from IDLE, before the captured rm is visible.
    assign w_rm     = w_accept ? cmd_rm : r_rm;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    unique case (op_t'(cmd_op))
                        OP_MOVI: w_next = S_WIMM;
                        OP_MOV:  w_next = S_LDB;
                        OP_ADD:  w_next = S_LDA;
                        OP_NOP:  w_next = S_FIN;
                        default: w_next = S_FIN;
                    endcase
                end
            end
            S_WIMM:  w_next = S_FIN;
            S_LDA:   w_next = S_LDB;
            S_LDB:   w_next = S_EXEC;
            S_EXEC:  w_next = S_WRC;
            S_WRC:   w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered against the state being entered, so they line up with r_state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_op       <= OP_NOP;
            r_rm       <= '0;
            r_imm      <= '0;
            r_readnum  <= '0;
            r_writenum <= '0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_write    <= 1'b0;
            r_loada    <= 1'b0;
            r_loadb    <= 1'b0;
            r_loadc    <= 1'b0;
            r_asel     <= 1'b0;
            r_vsel     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op       <= op_t'(cmd_op);
                r_rm       <= cmd_rm;
                r_imm      <= cmd_imm;
                r_writenum <= cmd_rd;
            end
            if (w_next == S_LDA) begin
                r_readnum <= cmd_rn;
            end else if (w_next == S_LDB) begin
                r_readnum <= w_rm;
            end
            r_ready <= (w_next == S_IDLE);
            r_done  <= (w_next == S_FIN);
            r_write <= (w_next == S_WIMM) || (w_next == S_WRC);
            r_vsel  <= (w_next == S_WIMM);
            r_loada <= (w_next == S_LDA);
            r_loadb <= (w_next == S_LDB);
            r_loadc <= (w_next == S_EXEC);
            r_asel  <= (w_next == S_EXEC) && (r_op == OP_MOV);
        end
    end

    assign cmd_ready = r_ready;
    assign done      = r_done;
    assign readnum   = r_readnum;
    assign writenum  = r_writenum;
    assign write     = r_write;
    assign loada     = r_loada;
    assign loadb     = r_loadb;
    assign loadc     = r_loadc;
    assign asel      = r_asel;
    assign vsel      = r_vsel;
    assign alu_op    = '0;
    assign imm_out   = r_imm;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a small datapath plant driven by the DUT strobes, plus a
// command-level model of the expected strobes and register contents checked every cycle.
`timescale 1ns/1ps
module tb_regfile_sequencer;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
    logic [15:0] cmd_imm;
    logic        done;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, asel, vsel;
    logic [1:0]  alu_op;
    logic [15:0] imm_out;

    regfile_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
        .cmd_imm(cmd_imm), .done(done),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc),
        .asel(asel), .vsel(vsel), .alu_op(alu_op), .imm_out(imm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit en      = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Datapath plant: register file, A/B operands, ALU (add) and C result.
    logic [15:0] rf [8] = '{default: '0};
    logic [15:0] pa = '0, pb = '0, pc = '0;
    always @(posedge clk) begin
        if (loada) pa <= rf[readnum];
        if (loadb) pb <= rf[readnum];
        if (loadc) pc <= (asel ? 16'd0 : pa) + pb;
        if (write) rf[writenum] <= vsel ? imm_out : pc;
    end

    // Expected per-cycle output image.
    typedef struct packed {
        logic        ready;
        logic        done;
        logic        write;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        asel;
        logic        vsel;
        logic [2:0]  rn;
        logic [2:0]  wn;
        logic [15:0] imm;
    } out_t;

    typedef struct packed {
        out_t        o;
        logic [15:0] wval;
    } ent_t;

    out_t        m_cur = '0;
    logic [15:0] m_wval = '0;
    ent_t        q[$];
    logic [15:0] mreg [8] = '{default: '0};
    logic [2:0]  m_rn_h = '0, m_wn_h = '0;
    logic [15:0] m_imm_h = '0;
    int          m_acc = 0;

    function automatic out_t st(input logic d, input logic w, input logic la, input logic lb,
                                input logic lc, input logic as, input logic vs);
        out_t o;
        o.ready = 1'b0; o.done = d; o.write = w; o.loada = la; o.loadb = lb;
        o.loadc = lc; o.asel = as; o.vsel = vs;
        o.rn = m_rn_h; o.wn = m_wn_h; o.imm = m_imm_h;
        return o;
    endfunction

    task automatic push(input out_t o, input logic [15:0] wv);
        ent_t e;
        e.o = o; e.wval = wv;
        q.push_back(e);
    endtask

    // Command-level model: each accepted command expands into its list of cycles.
    initial begin : model
        ent_t e;
        out_t idle;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                q.delete();
                m_rn_h = '0; m_wn_h = '0; m_imm_h = '0;
                m_cur = '0; m_wval = '0;
            end else begin
                if (m_cur.write) mreg[m_cur.wn] = m_wval;
                if (m_cur.ready && cmd_valid) begin
                    m_acc++;
                    m_wn_h  = cmd_rd;
                    m_imm_h = cmd_imm;
                    case (cmd_op)
                        2'b00: push(st(0, 1, 0, 0, 0, 0, 1), cmd_imm);
                        2'b01: begin
                            m_rn_h = cmd_rm;
                            push(st(0, 0, 0, 1, 0, 0, 0), '0);
                            push(st(0, 0, 0, 0, 1, 1, 0), '0);
                            push(st(0, 1, 0, 0, 0, 0, 0), mreg[cmd_rm]);
                        end
                        2'b10: begin
                            m_rn_h = cmd_rn;
                            push(st(0, 0, 1, 0, 0, 0, 0), '0);
                            m_rn_h = cmd_rm;
                            push(st(0, 0, 0, 1, 0, 0, 0), '0);
                            push(st(0, 0, 0, 0, 1, 0, 0), '0);
                            push(st(0, 1, 0, 0, 0, 0, 0), mreg[cmd_rn] + mreg[cmd_rm]);
                        end
                        default: ;
                    endcase
                    push(st(1, 0, 0, 0, 0, 0, 0), '0);
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    m_cur = e.o; m_wval = e.wval;
                end else begin
                    idle = st(0, 0, 0, 0, 0, 0, 0);
                    idle.ready = 1'b1;
                    m_cur = idle; m_wval = '0;
                end
            end
        end
    end

    initial begin : compare
        out_t o;
        int   bad;
        forever begin
            @(negedge clk);
            if (en) begin
                o.ready = cmd_ready; o.done = done; o.write = write; o.loada = loada;
                o.loadb = loadb; o.loadc = loadc; o.asel = asel; o.vsel = vsel;
                o.rn = readnum; o.wn = writenum; o.imm = imm_out;
                chk("outputs", 32'(o), 32'(m_cur));
                chk("alu_op", 32'(alu_op), 32'd0);
                bad = 0;
                for (int i = 0; i < 8; i++) if (rf[i] !== mreg[i]) bad++;
                chk("regfile", 32'(bad), 32'd0);
            end
        end
    end

    // Issue one command; returns cycles from accept to done and the first-cycle strobes.
    task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                         input logic [2:0] rm, input logic [15:0] imm,
                         output int lat, output logic [3:0] s1);
        int a0;
        bit got;
        @(negedge clk);
        cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_imm = imm;
        cmd_valid = 1'b1;
        a0 = m_acc; got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (m_acc != a0) got = 1'b1;
        end
        cmd_valid = 1'b0;
        chk("accept", 32'(got), 32'd1);
        lat = 0; s1 = '0;
        if (got) begin
            s1 = {write, vsel, loada, loadb};
            lat = 1;
            while (!done && lat < 20) begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    initial begin : stim
        int         lat, a0, first, second;
        logic [3:0] s1;
        reset_n = 1'b1; cmd_valid = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_imm = '0;
        #2 reset_n = 1'b0;
        #1 en = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(cmd_ready), 32'd0);
        chk("reset_outs", {cmd_ready, write, loada, loadb, loadc, asel, vsel, done,
                           readnum, writenum, alu_op, imm_out}, 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        issue(2'b00, 3'd0, 3'd0, 3'd0, 16'd20, lat, s1);
        chk("movi_first_cycle", 32'(s1), 32'b1100);
        chk("movi_done_lat", 32'(lat), 32'd2);
        chk("movi_r0", 32'(rf[0]), 32'd20);

        issue(2'b00, 3'd7, 3'd0, 3'd0, 16'd42, lat, s1);
        issue(2'b00, 3'd1, 3'd0, 3'd0, 16'd3, lat, s1);
        issue(2'b10, 3'd2, 3'd7, 3'd1, 16'h1234, lat, s1);
        chk("add_first_cycle", 32'(s1), 32'b0010);
        chk("add_done_lat", 32'(lat), 32'd5);
        chk("add_r2", 32'(rf[2]), 32'd45);

        issue(2'b01, 3'd3, 3'd5, 3'd7, 16'h0, lat, s1);
        chk("mov_first_cycle", 32'(s1), 32'b0001);
        chk("mov_done_lat", 32'(lat), 32'd4);
        chk("mov_r3", 32'(rf[3]), 32'd42);

        issue(2'b00, 3'd7, 3'd0, 3'd0, 16'hFFFF, lat, s1);
        issue(2'b10, 3'd7, 3'd7, 3'd7, 16'h0, lat, s1);
        chk("alias_wrap_r7", 32'(rf[7]), 32'h0000FFFE);

        // cmd_valid held high across an ADD; the follow-up NOP must wait for IDLE.
        @(negedge clk);
        cmd_op = 2'b10; cmd_rd = 3'd5; cmd_rn = 3'd2; cmd_rm = 3'd3; cmd_valid = 1'b1;
        a0 = m_acc; first = -1; second = -1;
        for (int k = 0; k < 40 && second < 0; k++) begin
            @(negedge clk);
            cmd_imm = 16'($urandom);
            if (first < 0 && m_acc == a0 + 1) begin
                first = k;
                cmd_op = 2'b11;
            end else if (m_acc == a0 + 2) begin
                second = k;
            end
        end
        cmd_valid = 1'b0;
        chk("held_valid_spacing", 32'(second - first), 32'd6);
        chk("nop_done", 32'(done), 32'd1);
        chk("nop_no_write", 32'(write), 32'd0);
        chk("held_add_r5", 32'(rf[5]), 32'd87);

        // Reset during LDB of an ADD aborts it without a write or done.
        @(negedge clk);
        cmd_op = 2'b10; cmd_rd = 3'd4; cmd_rn = 3'd7; cmd_rm = 3'd1; cmd_valid = 1'b1;
        a0 = m_acc;
        for (int k = 0; k < 20 && m_acc == a0; k++) @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_accept", 32'(m_acc - a0), 32'd1);
        @(negedge clk);
        chk("abort_in_ldb", 32'(loadb), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_outs_zero", {cmd_ready, write, loada, loadb, loadc, asel, vsel, done,
                                readnum, writenum, alu_op, imm_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_r4_unchanged", 32'(rf[4]), 32'd0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", 32'(cmd_ready), 32'd1);
        chk("abort_no_done", 32'(done), 32'd0);

        issue(2'b00, 3'd4, 3'd0, 3'd0, 16'd9, lat, s1);
        chk("post_abort_r4", 32'(rf[4]), 32'd9);

        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
